// File: rtl/lift_pkg.sv
// Shared types for the lift car/shaft model: car state encoding
// and the 2-bit protocol-violation codes reported on fault_code.
package lift_pkg;

   typedef enum logic [1:0] {
      ST_STOPPED   = 2'd0,
      ST_MOVING_UP = 2'd1,
      ST_MOVING_DN = 2'd2,
      ST_FAULT     = 2'd3
   } car_state_t;

   localparam logic [1:0] FLT_NONE        = 2'b00;
   localparam logic [1:0] FLT_DOOR_MOVING = 2'b01;
   localparam logic [1:0] FLT_OVERRUN     = 2'b10;
   localparam logic [1:0] FLT_DOOR_START  = 2'b11;

endpackage : lift_pkg

// File: rtl/segment_timer.sv
// Loadable down-counter timing one floor-to-floor segment.
// Ports: clk, rst_n (async low), load_i/load_val_i, en_i, done_o (count==0).
module segment_timer #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             en_i,
   output logic             done_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Load wins over decrement; the count parks at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = (cnt_q == '0);

endmodule : segment_timer

// File: rtl/lift_car_model.sv
// Simulated lift car and shaft driven by controller direction/motion/door_open.
// Ports: clk, reset (async low), direction, motion, door_open in;
//        floor_sense (one-hot), floor_idx, at_floor, fault, fault_code out.
module lift_car_model
   import lift_pkg::*;
#(
   parameter  int N_FLOORS        = 12,
   parameter  int TICKS_PER_FLOOR = 16,
   localparam int IDX_W           = $clog2(N_FLOORS),
   localparam int CNT_W           = $clog2(TICKS_PER_FLOOR)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                direction,
   input  logic                motion,
   input  logic                door_open,
   output logic [N_FLOORS-1:0] floor_sense,
   output logic [IDX_W-1:0]    floor_idx,
   output logic                at_floor,
   output logic                fault,
   output logic [1:0]          fault_code
);

   localparam logic [IDX_W-1:0] TOP_IDX  = IDX_W'(N_FLOORS - 1);
   localparam logic [CNT_W-1:0] SEG_LOAD = CNT_W'(TICKS_PER_FLOOR - 1);

   car_state_t          state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [N_FLOORS-1:0] sense_q, sense_d;
   logic                at_floor_q, at_floor_d;
   logic                fault_q, fault_d;
   logic [1:0]          code_q, code_d;

   logic tmr_load;
   logic tmr_en;
   logic tmr_done;
   logic mv_up;
   logic edge_hit;

   segment_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk        (clk),
      .rst_n      (reset),
      .load_i     (tmr_load),
      .load_val_i (SEG_LOAD),
      .en_i       (tmr_en),
      .done_o     (tmr_done)
   );

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      at_floor_d = at_floor_q;
      fault_d    = fault_q;
      code_d     = code_q;
      tmr_load   = 1'b0;
      tmr_en     = 1'b0;
      mv_up      = 1'b0;
      edge_hit   = 1'b0;

      unique case (state_q)
         ST_STOPPED: begin
            at_floor_d = 1'b1;
            edge_hit   = direction ? (idx_q == TOP_IDX)
                                   : (idx_q == '0);
            if (motion) begin
               if (door_open) begin
                  state_d    = ST_FAULT;
                  fault_d    = 1'b1;
                  code_d     = FLT_DOOR_START;
                  at_floor_d = 1'b0;
               end else if (edge_hit) begin
                  state_d    = ST_FAULT;
                  fault_d    = 1'b1;
                  code_d     = FLT_OVERRUN;
                  at_floor_d = 1'b0;
               end else begin
                  state_d    = direction ? ST_MOVING_UP
                                         : ST_MOVING_DN;
                  at_floor_d = 1'b0;
                  tmr_load   = 1'b1;
               end
            end
         end

         ST_MOVING_UP,
         ST_MOVING_DN: begin
            mv_up      = (state_q == ST_MOVING_UP);
            at_floor_d = 1'b0;
            // Door check outranks arrival on the final tick.
            if (door_open) begin
               state_d = ST_FAULT;
               fault_d = 1'b1;
               code_d  = FLT_DOOR_MOVING;
            end else if (!tmr_done) begin
               tmr_en = 1'b1;
            end else begin
               idx_d    = mv_up ? idx_q + 1'b1 : idx_q - 1'b1;
               edge_hit = mv_up ? (idx_d == TOP_IDX)
                                : (idx_d == '0);
               // Only a same-direction request chains segments;
               // a reversal always passes through STOPPED.
               if (motion && (direction == mv_up)) begin
                  if (edge_hit) begin
                     state_d = ST_FAULT;
                     fault_d = 1'b1;
                     code_d  = FLT_OVERRUN;
                  end else begin
                     tmr_load   = 1'b1;
                     at_floor_d = 1'b1;
                  end
               end else begin
                  state_d    = ST_STOPPED;
                  at_floor_d = 1'b1;
               end
            end
         end

         ST_FAULT: begin
            at_floor_d = 1'b0;
         end
      endcase
   end

   // One-hot position is registered from the next index so it
   // always tracks floor_idx on the same cycle.
   always_comb begin
      sense_d        = '0;
      sense_d[idx_d] = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_STOPPED;
         idx_q      <= '0;
         sense_q    <= N_FLOORS'(1);
         at_floor_q <= 1'b1;
         fault_q    <= 1'b0;
         code_q     <= FLT_NONE;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         sense_q    <= sense_d;
         at_floor_q <= at_floor_d;
         fault_q    <= fault_d;
         code_q     <= code_d;
      end
   end

   assign floor_sense = sense_q;
   assign floor_idx   = idx_q;
   assign at_floor    = at_floor_q;
   assign fault       = fault_q;
   assign fault_code  = code_q;

endmodule : lift_car_model

// File: tb/tb_lift_car_model.sv
// Bench for lift_car_model: directed scenarios plus random traffic,
// each cycle compared against a tick-counting reference model.
module tb_lift_car_model;

   localparam int N = 12;
   localparam int T = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          direction;
   logic          motion;
   logic          door_open;
   logic [N-1:0]  floor_sense;
   logic [3:0]    floor_idx;
   logic          at_floor;
   logic          fault;
   logic [1:0]    fault_code;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference: floor number, whether a trip is in progress, its
   // direction, and how many edges of the current segment elapsed.
   int m_floor;
   int m_elapsed;
   int m_code;
   bit m_moving;
   bit m_dir;
   bit m_fault;
   bit m_atf;

   always #5 clk = ~clk;

   lift_car_model #(
      .N_FLOORS        (N),
      .TICKS_PER_FLOOR (T)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .direction   (direction),
      .motion      (motion),
      .door_open   (door_open),
      .floor_sense (floor_sense),
      .floor_idx   (floor_idx),
      .at_floor    (at_floor),
      .fault       (fault),
      .fault_code  (fault_code)
   );

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic m_trip_fault(input int code);
      m_fault  = 1'b1;
      m_code   = code;
      m_moving = 1'b0;
      m_atf    = 1'b0;
   endtask

   task automatic model_reset();
      m_floor   = 0;
      m_elapsed = 0;
      m_code    = 0;
      m_moving  = 1'b0;
      m_dir     = 1'b0;
      m_fault   = 1'b0;
      m_atf     = 1'b1;
   endtask

   task automatic model_step();
      int step;
      if (m_fault) begin
         m_atf = 1'b0;
      end else if (!m_moving) begin
         m_atf = 1'b1;
         if (motion) begin
            if (door_open) begin
               m_trip_fault(3);
            end else if ((direction && m_floor == N - 1) ||
                         (!direction && m_floor == 0)) begin
               m_trip_fault(2);
            end else begin
               m_moving  = 1'b1;
               m_dir     = direction;
               m_elapsed = 1;
               m_atf     = 1'b0;
            end
         end
      end else if (door_open) begin
         m_trip_fault(1);
      end else if (m_elapsed < T) begin
         m_elapsed++;
         m_atf = 1'b0;
      end else begin
         step    = m_dir ? 1 : -1;
         m_floor = m_floor + step;
         if (motion && direction == m_dir) begin
            if (m_floor + step < 0 || m_floor + step >= N) begin
               m_trip_fault(2);
            end else begin
               m_elapsed = 1;
               m_atf     = 1'b1;
            end
         end else begin
            m_moving = 1'b0;
            m_atf    = 1'b1;
         end
      end
   endtask

   task automatic compare_all();
      check_eq("floor_idx", int'(floor_idx), m_floor);
      check_eq("floor_sense", int'(floor_sense), 1 << m_floor);
      check_eq("at_floor", int'(at_floor), int'(m_atf));
      check_eq("fault", int'(fault), int'(m_fault));
      check_eq("fault_code", int'(fault_code), m_code);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   // Called 1 time unit after a rising edge; asserts reset
   // asynchronously and releases it away from the edge.
   task automatic do_reset();
      reset     = 1'b0;
      motion    = 1'b0;
      door_open = 1'b0;
      #1;
      model_reset();
      compare_all();
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic run_random(input int cycles);
      for (int c = 0; c < cycles; c++) begin
         if (m_fault && $urandom_range(7) == 0) begin
            do_reset();
         end else if ($urandom_range(499) == 0) begin
            do_reset();
         end else begin
            motion    = ($urandom_range(7) != 0);
            door_open = ($urandom_range(63) == 0);
            if (m_floor == N - 1 && $urandom_range(9) < 8) begin
               direction = 1'b0;
            end else if (m_floor == 0 && $urandom_range(9) < 8) begin
               direction = 1'b1;
            end else if ($urandom_range(11) == 0) begin
               direction = ~direction;
            end
            tick();
         end
      end
   endtask

   initial begin
      reset     = 1'b1;
      direction = 1'b1;
      motion    = 1'b0;
      door_open = 1'b0;
      model_reset();
      #2;
      do_reset();
      check_eq("rst_sense", int'(floor_sense), 1);
      check_eq("rst_atf", int'(at_floor), 1);

      // Three floors up, motion dropped before the third arrival.
      direction = 1'b1;
      motion    = 1'b1;
      for (int i = 1; i <= 49; i++) begin
         if (i == 41) motion = 1'b0;
         tick();
         if (i == 17) check_eq("pulse16", int'(at_floor), 1);
         if (i == 18) check_eq("pulse16_end", int'(at_floor), 0);
         if (i == 33) check_eq("pulse32", int'(at_floor), 1);
         if (i == 48) check_eq("pre_arrive3", int'(floor_idx), 2);
      end
      check_eq("arrive3_sense", int'(floor_sense), 12'h008);
      check_eq("arrive3_atf", int'(at_floor), 1);
      tick();
      check_eq("stay3", int'(floor_idx), 3);

      // Motion dropped mid-segment still completes the segment.
      do_reset();
      motion = 1'b1;
      for (int i = 1; i <= 17; i++) begin
         if (i == 6) motion = 1'b0;
         tick();
         if (i == 16) check_eq("mid_not_yet", int'(at_floor), 0);
      end
      check_eq("mid_arrive", int'(floor_idx), 1);
      check_eq("mid_nofault", int'(fault), 0);

      // Down from floor 0 is an overrun.
      do_reset();
      direction = 1'b0;
      motion    = 1'b1;
      tick();
      check_eq("ovr_code", int'(fault_code), 2);
      check_eq("ovr_idx", int'(floor_idx), 0);
      motion = 1'b0;
      tick();

      // Door opens at tick 7 of the second segment.
      do_reset();
      direction = 1'b1;
      motion    = 1'b1;
      for (int i = 1; i <= 24; i++) begin
         if (i == 24) door_open = 1'b1;
         tick();
      end
      check_eq("door_code", int'(fault_code), 1);
      check_eq("door_frozen", int'(floor_idx), 1);
      door_open = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      do_reset();
      check_eq("door_clr_idx", int'(floor_idx), 0);

      // Motion with door open at start; later violations ignored.
      motion    = 1'b1;
      door_open = 1'b1;
      tick();
      check_eq("start_code", int'(fault_code), 3);
      door_open = 1'b0;
      direction = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      check_eq("first_wins", int'(fault_code), 3);

      // Reversal on arrival at floor 2.
      do_reset();
      direction = 1'b1;
      motion    = 1'b1;
      for (int i = 1; i <= 50; i++) begin
         if (i == 33) direction = 1'b0;
         tick();
         if (i == 33) check_eq("rev_stop", int'(at_floor), 1);
         if (i == 34) check_eq("rev_depart", int'(at_floor), 0);
         if (i == 49) check_eq("rev_pre", int'(floor_idx), 2);
      end
      check_eq("rev_arrive", int'(floor_idx), 1);

      // Reset in the middle of a segment above floor 0.
      do_reset();
      direction = 1'b1;
      motion    = 1'b1;
      for (int i = 1; i <= 22; i++) tick();
      do_reset();
      check_eq("midrst_idx", int'(floor_idx), 0);

      run_random(4000);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_lift_car_model

// File: doc/lift_car_model.md
# lift_car_model

Behavioural-synthesizable model of the lift car and shaft, sitting on the far side of the controller interface. It consumes the controller's `direction`, `motion` and `door_open` outputs, moves a simulated car between floors with a fixed per-floor travel time, and drives back `floor_sense` plus status. It closes the loop for system-level simulation and FPGA demo builds, and flags protocol violations by the controller.

## Interface
Parameters:
- `N_FLOORS`, 12, number of floors (>= 2)
- `TICKS_PER_FLOOR`, 16, clock cycles to travel one floor (>= 2)

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `direction`  in  1  1 = up, 0 = down (from controller)
- `motion`  in  1  1 = controller commands car to move
- `door_open`  in  1  door state from controller
- `floor_sense`  out  N_FLOORS  one-hot, current or last-passed floor
- `floor_idx`  out  $clog2(N_FLOORS)  binary index of `floor_sense`
- `at_floor`  out  1  car is level at `floor_idx`
- `fault`  out  1  sticky protocol-violation flag
- `fault_code`  out  2  00 none, 01 door open while moving, 10 overrun past top/bottom, 11 motion with door open at start

## Operation
- States: STOPPED, MOVING_UP, MOVING_DN, FAULT.
- STOPPED: `at_floor`=1. If `motion`=1:
  - `door_open`=1 -> FAULT, code 11.
  - Up at top floor, or down at floor 0 -> FAULT, code 10.
  - Otherwise -> MOVING_UP/MOVING_DN. Segment counter loads TICKS_PER_FLOOR-1.
- MOVING_x: `at_floor`=0, and `floor_sense` holds the departed floor. The counter decrements each cycle.
  - `door_open`=1 in any MOVING cycle -> FAULT, code 01. This check takes priority over arrival.
  - `direction` and `motion` are ignored mid-segment. The car always completes the segment.
  - Counter==0: `floor_idx` ±1 and `floor_sense` shifts. Then:
    - If `motion`=1, `direction` is unchanged and the next floor exists: stay in MOVING_x, reload the counter, and pulse `at_floor` for 1 cycle.
    - If `motion`=1 but the next floor does not exist in the same direction: go to FAULT, code 10.
    - Otherwise -> STOPPED.
  - A direction reversal with `motion`=1 on arrival -> STOPPED for one cycle, then depart the opposite way.
- FAULT: sticky until `reset`.
  - The car halts; `floor_sense`/`floor_idx` hold their values and `at_floor`=0.
  - `fault`=1 and `fault_code` is frozen. First fault wins.
- `floor_sense` is always exactly one-hot and always equals 1 << `floor_idx`.

## Timing
- Reset values: state STOPPED, `floor_idx`=0, `floor_sense`=1, `at_floor`=1, `fault`=0, `fault_code`=00, counter 0.
- Reset is asynchronous assert; deassertion is synchronous to `clk`.
- Reset mid-segment returns the car to floor 0 immediately.
- Departure: `motion` sampled high at edge k -> state MOVING and `at_floor`=0 after edge k.
- Arrival: floor update and `at_floor`=1 after edge k+TICKS_PER_FLOOR. Transit = exactly TICKS_PER_FLOOR cycles per floor.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Fault detection: `fault` is high the cycle after the offending input is sampled.

## Structure
- Shared package `lift_pkg`:
  - state enum `car_state_t`
  - fault code localparams `FLT_NONE`, `FLT_DOOR_MOVING`, `FLT_OVERRUN`, `FLT_DOOR_START`
- Sub-module `segment_timer`: loadable down-counter of width $clog2(TICKS_PER_FLOOR), with `load`, `en` and a `done` flag at count 0.
- Top-level FSM plus floor index register.
- `floor_sense` is decoded from `floor_idx` into a register.

## Test plan
- Reset, then `motion`=1 with `direction`=1 held for 3 floors (TICKS_PER_FLOOR=16) -> `floor_idx` reaches 3 at cycle 48. `at_floor` pulses at 16 and 32. Drop `motion` before cycle 48 -> car ends STOPPED, `floor_sense`=0x008.
- Drop `motion` mid-segment at tick 5 -> car still arrives at floor 1 at tick 16, then STOPPED, no fault.
- From floor 0, `motion`=1 with `direction`=0 -> `fault`=1, code 10, `floor_idx` stays 0.
- `door_open`=1 at tick 7 of a segment -> `fault`=1, code 01 next cycle. Car frozen at departed floor, `at_floor`=0. A later `reset` low clears to floor 0.
- In STOPPED, assert `motion` and `door_open` together -> code 11. Subsequent violations do not change `fault_code`.
- Reversal: travel up to floor 2, then on the arrival cycle flip `direction` with `motion` held -> one STOPPED cycle at floor 2, then reach floor 1 16 cycles after departure.
